// File: rtl/sprite_scheduler.sv
// sprite_scheduler: round-robin EN/finish initiator for the sprite engines.
// Forwards the owning engine's pixel writes to the single VGA adapter port.
module sprite_scheduler #(
  parameter int N_SPRITES = 5,
  parameter int IDXW      = 3,
  parameter int TIMEOUT   = 100000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   run,
  input  logic [N_SPRITES-1:0]   mask,
  input  logic [N_SPRITES-1:0]   finish_in,
  input  logic [N_SPRITES-1:0]   plot_in,
  input  logic [8*N_SPRITES-1:0] x_in,
  input  logic [7*N_SPRITES-1:0] y_in,
  input  logic [3*N_SPRITES-1:0] colour_in,
  output logic [N_SPRITES-1:0]   en_out,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot,
  output logic [IDXW-1:0]        active_idx,
  output logic                   busy,
  output logic                   round_done,
  output logic [N_SPRITES-1:0]   timeout_err
);

  // state     | meaning
  // IDLE      | not scheduling; waits for run with a non-empty mask
  // ISSUE     | one-cycle EN to active_idx, timeout timer loaded
  // WAIT_DONE | active engine owns the VGA port; wait for finish or timeout
  // ADVANCE   | pick next masked engine above active_idx, wrap = end of round
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, ADVANCE} state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);

  state_t               state;
  logic [TW-1:0]        timer;
  logic [N_SPRITES-1:0] act_onehot;
  logic [N_SPRITES-1:0] nxt_onehot;
  logic [N_SPRITES-1:0] low_onehot;
  logic [IDXW-1:0]      above_idx;
  logic [IDXW-1:0]      lowest_idx;
  logic [IDXW-1:0]      nxt_idx;
  logic                 found_above;
  logic                 wrapped;
  logic                 others_set;
  logic                 fin_sel;
  logic                 plot_sel;
  logic [7:0]           x_sel;
  logic [6:0]           y_sel;
  logic [2:0]           c_sel;

  // Descending scan so the final write to lowest_idx/above_idx is the smallest match.
  always_comb begin
    above_idx   = '0;
    lowest_idx  = '0;
    found_above = 1'b0;
    act_onehot  = '0;
    nxt_onehot  = '0;
    fin_sel     = 1'b0;
    plot_sel    = 1'b0;
    x_sel       = '0;
    y_sel       = '0;
    c_sel       = '0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest_idx = IDXW'(i);
        if (i > int'(active_idx)) begin
          above_idx   = IDXW'(i);
          found_above = 1'b1;
        end
      end
      if (active_idx == IDXW'(i)) begin
        act_onehot[i] = 1'b1;
        fin_sel       = finish_in[i];
        plot_sel      = plot_in[i];
        x_sel         = x_in[8*i +: 8];
        y_sel         = y_in[7*i +: 7];
        c_sel         = colour_in[3*i +: 3];
      end
    end
    wrapped = !found_above;
    nxt_idx = found_above ? above_idx : lowest_idx;
    for (int i = 0; i < N_SPRITES; i++) begin
      if (nxt_idx == IDXW'(i)) nxt_onehot[i] = 1'b1;
    end
    low_onehot = mask & (~mask + N_SPRITES'(1));
    others_set = |(mask & ~act_onehot);
  end

  assign vga_plot   = (state == WAIT_DONE) && plot_sel;
  assign vga_x      = (state == WAIT_DONE) ? x_sel : '0;
  assign vga_y      = (state == WAIT_DONE) ? y_sel : '0;
  assign vga_colour = (state == WAIT_DONE) ? c_sel : '0;
  assign busy       = (state != IDLE);
  assign round_done = (state == ADVANCE) && (wrapped || !others_set);

  // en_out is registered on entry to ISSUE so it is high for exactly that cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      active_idx  <= '0;
      timer       <= '0;
      en_out      <= '0;
      timeout_err <= '0;
    end else begin
      en_out <= '0;
      case (state)
        IDLE: begin
          if (run && (|mask)) begin
            active_idx <= lowest_idx;
            en_out     <= low_onehot;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= TIMER_LOAD;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          timer <= timer - TW'(1);
          if (fin_sel) begin
            state <= ADVANCE;
          end else if (timer == '0) begin
            timeout_err <= timeout_err | act_onehot;
            state       <= ADVANCE;
          end
        end
        ADVANCE: begin
          if ((mask == '0) || (wrapped && !run)) begin
            state <= IDLE;
          end else begin
            active_idx <= nxt_idx;
            en_out     <= nxt_onehot;
            state      <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler: three instances differing only in TIMEOUT
// share one stimulus set; each scenario checks the instance selected by sel.
module tb_sprite_scheduler;
  localparam int N = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           resetn;
  logic           run;
  logic [N-1:0]   mask;
  logic [N-1:0]   finish_in;
  logic [N-1:0]   plot_in;
  logic [8*N-1:0] x_in;
  logic [7*N-1:0] y_in;
  logic [3*N-1:0] colour_in;

  logic [N-1:0] en_all  [3];
  logic [7:0]   vx_all  [3];
  logic [6:0]   vy_all  [3];
  logic [2:0]   vc_all  [3];
  logic         vp_all  [3];
  logic [2:0]   act_all [3];
  logic         busy_all[3];
  logic         rd_all  [3];
  logic [N-1:0] err_all [3];

  // Instance 0: TIMEOUT=100000, 1: TIMEOUT=16, 2: TIMEOUT=8.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    sprite_scheduler #(
      .N_SPRITES(N),
      .IDXW(3),
      .TIMEOUT(g == 0 ? 100000 : (g == 1 ? 16 : 8))
    ) u_dut (
      .clk(clk),
      .resetn(resetn),
      .run(run),
      .mask(mask),
      .finish_in(finish_in),
      .plot_in(plot_in),
      .x_in(x_in),
      .y_in(y_in),
      .colour_in(colour_in),
      .en_out(en_all[g]),
      .vga_x(vx_all[g]),
      .vga_y(vy_all[g]),
      .vga_colour(vc_all[g]),
      .vga_plot(vp_all[g]),
      .active_idx(act_all[g]),
      .busy(busy_all[g]),
      .round_done(rd_all[g]),
      .timeout_err(err_all[g])
    );
  end

  int sel = 0;
  int checks = 0;
  int errors = 0;

  logic [N-1:0] en_s, err_s;
  logic [7:0]   vx_s;
  logic [6:0]   vy_s;
  logic [2:0]   vc_s, act_s;
  logic         vp_s, busy_s, rd_s;

  assign en_s   = en_all[sel];
  assign err_s  = err_all[sel];
  assign vx_s   = vx_all[sel];
  assign vy_s   = vy_all[sel];
  assign vc_s   = vc_all[sel];
  assign act_s  = act_all[sel];
  assign vp_s   = vp_all[sel];
  assign busy_s = busy_all[sel];
  assign rd_s   = rd_all[sel];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    resetn    = 1'b0;
    run       = 1'b0;
    mask      = '0;
    finish_in = '0;
    plot_in   = '0;
    x_in      = '0;
    y_in      = '0;
    colour_in = '0;
    repeat (2) step();
  endtask

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_busy"}, 32'(busy_s), 32'd0);
    check_val({tag, "_act"},  32'(act_s),  32'd0);
    check_val({tag, "_en"},   32'(en_s),   32'd0);
    check_val({tag, "_rd"},   32'(rd_s),   32'd0);
    check_val({tag, "_err"},  32'(err_s),  32'd0);
    check_val({tag, "_plot"}, 32'(vp_s),   32'd0);
    check_val({tag, "_x"},    32'(vx_s),   32'd0);
    check_val({tag, "_y"},    32'(vy_s),   32'd0);
    check_val({tag, "_col"},  32'(vc_s),   32'd0);
  endtask

  // Waits (bounded) for the EN pulse, checks it targets idx, lasts one cycle.
  // Returns in the first WAIT_DONE cycle.
  task automatic start_engine(input int idx, input int gap);
    int n = 0;
    while (en_s == '0 && n < 64) begin
      step();
      n++;
    end
    check_val("en_onehot", 32'(en_s), 32'(1 << idx));
    check_val("en_active_idx", 32'(act_s), 32'(idx));
    if (gap >= 0) check_val("issue_gap", 32'(n), 32'(gap));
    step();
    check_val("en_width", 32'(en_s), 32'd0);
    check_val("busy_wait", 32'(busy_s), 32'd1);
  endtask

  // Asserts finish at WAIT_DONE cycle (n_wait+1) from the current one; returns in ADVANCE.
  task automatic finish_engine(input int idx, input int n_wait, input logic exp_rd);
    repeat (n_wait) step();
    finish_in = N'(1) << idx;
    step();
    finish_in = '0;
    check_val("round_done", 32'(rd_s), 32'(exp_rd));
  endtask

  initial begin
    int en_seen;

    // Reset values and round-robin over mask 10101, finish 40 cycles after EN.
    sel = 0;
    reset_all();
    check_idle_zero("reset");
    resetn = 1'b1;
    run    = 1'b1;
    mask   = 5'b10101;
    start_engine(0, -1);
    finish_engine(0, 39, 1'b0);
    start_engine(2, 1);

    // Engine 2 owns the VGA port; engine 0's strobe must not leak through.
    x_in[23:16]     = 8'd102;
    y_in[20:14]     = 7'd27;
    colour_in[8:6]  = 3'b110;
    x_in[7:0]       = 8'd55;
    y_in[6:0]       = 7'd9;
    colour_in[2:0]  = 3'b011;
    plot_in         = 5'b00101;
    #1;
    check_val("vga_plot_e2", 32'(vp_s), 32'd1);
    check_val("vga_x_e2",    32'(vx_s), 32'd102);
    check_val("vga_y_e2",    32'(vy_s), 32'd27);
    check_val("vga_col_e2",  32'(vc_s), 32'd6);
    plot_in = 5'b00001;
    #1;
    check_val("vga_plot_other", 32'(vp_s), 32'd0);
    finish_engine(2, 39, 1'b0);
    plot_in = '1;
    #1;
    check_val("vga_plot_adv", 32'(vp_s), 32'd0);
    check_val("vga_x_adv",    32'(vx_s), 32'd0);
    check_val("vga_y_adv",    32'(vy_s), 32'd0);
    plot_in = '0;
    start_engine(4, 1);
    finish_engine(4, 39, 1'b1);
    start_engine(0, 1);
    finish_engine(0, 39, 1'b0);
    start_engine(2, 1);

    // run dropped while engine 3 is active: engine 4 still served, then IDLE.
    reset_all();
    resetn = 1'b1;
    run    = 1'b1;
    mask   = 5'b11111;
    start_engine(0, -1);
    finish_engine(0, 4, 1'b0);
    start_engine(1, 1);
    finish_engine(1, 4, 1'b0);
    start_engine(2, 1);
    finish_engine(2, 4, 1'b0);
    start_engine(3, 1);
    run = 1'b0;
    finish_engine(3, 4, 1'b0);
    start_engine(4, 1);
    finish_engine(4, 4, 1'b1);
    step();
    check_val("stop_busy", 32'(busy_s), 32'd0);
    check_val("stop_en",   32'(en_s),   32'd0);
    en_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (en_s != '0) en_seen++;
    end
    check_val("stop_no_en", 32'(en_seen), 32'd0);

    // Reset during WAIT_DONE of engine 1, then restart from engine 0.
    run = 1'b1;
    start_engine(0, -1);
    finish_engine(0, 4, 1'b0);
    start_engine(1, 1);
    plot_in     = 5'b00010;
    x_in[15:8]  = 8'd200;
    #1;
    check_val("pre_rst_plot", 32'(vp_s), 32'd1);
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check_idle_zero("midrst");
    plot_in = '0;
    start_engine(0, 1);

    // TIMEOUT=16 instance: engine 1 never finishes.
    reset_all();
    sel    = 1;
    resetn = 1'b1;
    run    = 1'b1;
    mask   = 5'b00111;
    start_engine(0, -1);
    finish_engine(0, 9, 1'b0);
    start_engine(1, 1);
    repeat (15) step();
    check_val("to_err_c16", 32'(err_s), 32'd0);
    step();
    check_val("to_err_set", 32'(err_s), 32'b00010);
    check_val("to_rd",      32'(rd_s),  32'd0);
    start_engine(2, 1);
    finish_engine(2, 9, 1'b1);
    start_engine(0, 1);
    check_val("to_err_sticky1", 32'(err_s), 32'b00010);
    finish_engine(0, 9, 1'b0);
    start_engine(1, 1);
    finish_engine(1, 9, 1'b0);
    check_val("to_err_sticky2", 32'(err_s), 32'b00010);

    // TIMEOUT=8 instance: finish on the 8th WAIT_DONE cycle beats the timeout.
    reset_all();
    check_val("err_cleared_rst", 32'(err_all[1]), 32'd0);
    sel    = 2;
    resetn = 1'b1;
    run    = 1'b1;
    mask   = 5'b00011;
    start_engine(0, -1);
    finish_engine(0, 7, 1'b0);
    check_val("coincide_err", 32'(err_s), 32'd0);
    start_engine(1, 1);
    repeat (7) step();
    check_val("t8_err_c8", 32'(err_s), 32'd0);
    step();
    check_val("t8_err_set", 32'(err_s), 32'b00010);
    check_val("t8_rd",      32'(rd_s),  32'd1);
    start_engine(0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
